// File: rtl/pwm_cfg_scheduler.sv
// PWM configuration scheduler: immediate output-enable writes, staged
// PWM enable/duty writes committed atomically at a period boundary.
module pwm_cfg_scheduler #(
    parameter int unsigned PERIOD_TIMEOUT = 1024,
    parameter logic [4:0]  IMMEDIATE_MASK = 5'b00011
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       wr_valid,
    input  logic [3:0] wr_addr,
    input  logic [7:0] wr_data,
    output logic       wr_ready,
    input  logic       period_end,
    output logic [7:0] en_reg_out_7_0,
    output logic [7:0] en_reg_out_15_8,
    output logic [7:0] en_reg_pwm_7_0,
    output logic [7:0] en_reg_pwm_15_8,
    output logic [7:0] pwm_duty_cycle,
    output logic [4:0] pending,
    output logic       commit_pulse,
    output logic       addr_err
);

    localparam int unsigned TW =
        (PERIOD_TIMEOUT > 2) ? $clog2(PERIOD_TIMEOUT) : 1;
    localparam logic [TW-1:0] T_LAST = TW'(PERIOD_TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        PENDING,
        COMMIT
    } state_t;

    state_t        state_q;
    state_t        state_d;
    logic [TW-1:0] tcnt_q;
    logic [7:0]    act_q    [5];
    logic [7:0]    shadow_q [5];
    logic [4:0]    pending_q;
    logic          addr_err_q;

    logic          accept;
    logic          addr_ok;
    logic [4:0]    wr_sel;
    logic [4:0]    stg_sel;
    logic          timeout;

    assign accept  = wr_valid & wr_ready;
    assign addr_ok = (wr_addr <= 4'd4);
    assign timeout = (tcnt_q == T_LAST);

    always_comb begin
        wr_sel = '0;
        if (accept && addr_ok) begin
            wr_sel = 5'(1) << wr_addr;
        end
    end

    assign stg_sel = wr_sel & ~IMMEDIATE_MASK;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (|stg_sel) state_d = PENDING;
            end
            PENDING: begin
                if (period_end || timeout) state_d = COMMIT;
            end
            COMMIT: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output logic
    always_comb begin
        wr_ready     = 1'b1;
        commit_pulse = 1'b0;
        unique case (state_q)
            IDLE:    wr_ready = 1'b1;
            PENDING: wr_ready = 1'b1;
            COMMIT: begin
                wr_ready     = 1'b0;
                commit_pulse = 1'b1;
            end
            default: wr_ready = 1'b1;
        endcase
    end

    // Started once per PENDING episode; later writes leave it alone
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tcnt_q <= '0;
        end else if (state_q == IDLE && state_d == PENDING) begin
            tcnt_q <= '0;
        end else if (state_q == PENDING && !timeout) begin
            tcnt_q <= tcnt_q + TW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int a = 0; a < 5; a++) begin
                act_q[a]    <= '0;
                shadow_q[a] <= '0;
            end
            pending_q  <= '0;
            addr_err_q <= 1'b0;
        end else begin
            for (int a = 0; a < 5; a++) begin
                if (wr_sel[a] && IMMEDIATE_MASK[a]) begin
                    act_q[a] <= wr_data;
                end else if (state_q == COMMIT && pending_q[a]) begin
                    act_q[a] <= shadow_q[a];
                end
                if (stg_sel[a]) begin
                    shadow_q[a] <= wr_data;
                end
            end
            if (state_q == COMMIT) begin
                pending_q <= '0;
            end else begin
                pending_q <= pending_q | stg_sel;
            end
            addr_err_q <= accept & ~addr_ok;
        end
    end

    assign en_reg_out_7_0  = act_q[0];
    assign en_reg_out_15_8 = act_q[1];
    assign en_reg_pwm_7_0  = act_q[2];
    assign en_reg_pwm_15_8 = act_q[3];
    assign pwm_duty_cycle  = act_q[4];
    assign pending         = pending_q;
    assign addr_err        = addr_err_q;

endmodule

// File: tb/tb_pwm_cfg_scheduler.sv
// Bench for pwm_cfg_scheduler: directed scenarios plus random traffic,
// all checked against a transaction-level model of the register schedule.
module tb_pwm_cfg_scheduler;

    localparam int         T    = 16;
    localparam logic [4:0] MASK = 5'b00011;

    logic       clk;
    logic       rst_n;
    logic       wr_valid;
    logic [3:0] wr_addr;
    logic [7:0] wr_data;
    logic       wr_ready;
    logic       period_end;
    logic [7:0] en_reg_out_7_0;
    logic [7:0] en_reg_out_15_8;
    logic [7:0] en_reg_pwm_7_0;
    logic [7:0] en_reg_pwm_15_8;
    logic [7:0] pwm_duty_cycle;
    logic [4:0] pending;
    logic       commit_pulse;
    logic       addr_err;

    pwm_cfg_scheduler #(
        .PERIOD_TIMEOUT(T),
        .IMMEDIATE_MASK(MASK)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .wr_valid       (wr_valid),
        .wr_addr        (wr_addr),
        .wr_data        (wr_data),
        .wr_ready       (wr_ready),
        .period_end     (period_end),
        .en_reg_out_7_0 (en_reg_out_7_0),
        .en_reg_out_15_8(en_reg_out_15_8),
        .en_reg_pwm_7_0 (en_reg_pwm_7_0),
        .en_reg_pwm_15_8(en_reg_pwm_15_8),
        .pwm_duty_cycle (pwm_duty_cycle),
        .pending        (pending),
        .commit_pulse   (commit_pulse),
        .addr_err       (addr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: register contents plus a "waiting for boundary"
    // flag with the number of cycles waited, and a "committing" flag.
    logic [7:0] m_act [5];
    logic [7:0] m_sh  [5];
    logic [4:0] m_pend;
    bit         m_wait;
    bit         m_com;
    bit         m_err;
    int         m_age;

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 5; i++) begin
            m_act[i] = '0;
            m_sh[i]  = '0;
        end
        m_pend = '0;
        m_wait = 0;
        m_com  = 0;
        m_err  = 0;
        m_age  = 0;
    endtask

    task automatic model_edge(input logic v, input logic [3:0] a,
                              input logic [7:0] d, input logic pe,
                              output bit acc);
        bit go;
        bit staged;
        int ai;
        acc    = v && !m_com;
        go     = m_wait && (pe || m_age >= T - 1);
        staged = 0;
        m_err  = acc && (a > 4);
        if (m_com) begin
            for (int i = 0; i < 5; i++)
                if (m_pend[i]) m_act[i] = m_sh[i];
            m_pend = '0;
            m_com  = 0;
        end
        if (acc && a <= 4) begin
            ai = int'(a);
            if (MASK[ai]) begin
                m_act[ai] = d;
            end else begin
                m_sh[ai]   = d;
                m_pend[ai] = 1'b1;
                staged     = 1;
            end
        end
        if (m_wait) begin
            if (go) begin
                m_wait = 0;
                m_com  = 1;
            end else if (m_age < T - 1) begin
                m_age++;
            end
        end else if (staged) begin
            m_wait = 1;
            m_age  = 0;
        end
    endtask

    task automatic check_all();
        chk("out_7_0", en_reg_out_7_0, m_act[0]);
        chk("out_15_8", en_reg_out_15_8, m_act[1]);
        chk("pwm_7_0", en_reg_pwm_7_0, m_act[2]);
        chk("pwm_15_8", en_reg_pwm_15_8, m_act[3]);
        chk("duty", pwm_duty_cycle, m_act[4]);
        chk("pending", 8'(pending), 8'(m_pend));
        chk("commit_pulse", 8'(commit_pulse), 8'(m_com));
        chk("wr_ready", 8'(wr_ready), 8'(!m_com));
        chk("addr_err", 8'(addr_err), 8'(m_err));
    endtask

    // Called at a negedge; one clock with the given inputs, then check.
    task automatic step(input logic v, input logic [3:0] a,
                        input logic [7:0] d, input logic pe,
                        output bit acc);
        wr_valid   = v;
        wr_addr    = a;
        wr_data    = d;
        period_end = pe;
        @(posedge clk);
        model_edge(v, a, d, pe, acc);
        @(negedge clk);
        wr_valid   = 1'b0;
        period_end = 1'b0;
        check_all();
    endtask

    task automatic idle(input int n);
        bit acc;
        for (int i = 0; i < n; i++) step(1'b0, 4'd0, 8'd0, 1'b0, acc);
    endtask

    initial begin
        bit acc;
        rst_n      = 1'b0;
        wr_valid   = 1'b0;
        wr_addr    = '0;
        wr_data    = '0;
        period_end = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check_all();
        chk("rst_ready", 8'(wr_ready), 8'd1);
        rst_n = 1'b1;

        // Immediate write
        step(1'b1, 4'd0, 8'hA5, 1'b0, acc);
        chk("imm_a5", en_reg_out_7_0, 8'hA5);
        chk("imm_pend", 8'(pending), 8'd0);

        // Single staged write committed by period_end
        step(1'b1, 4'd4, 8'h80, 1'b0, acc);
        chk("stg_pend", 8'(pending), 8'h10);
        chk("stg_duty0", pwm_duty_cycle, 8'h00);
        step(1'b0, 4'd0, 8'd0, 1'b1, acc);
        chk("stg_commit", 8'(commit_pulse), 8'd1);
        chk("stg_duty1", pwm_duty_cycle, 8'h00);
        idle(1);
        chk("stg_duty2", pwm_duty_cycle, 8'h80);
        chk("stg_clr", 8'(pending), 8'd0);

        // Several staged writes, last value wins, same-edge update
        step(1'b1, 4'd2, 8'h0F, 1'b0, acc);
        step(1'b1, 4'd4, 8'h40, 1'b0, acc);
        step(1'b1, 4'd4, 8'h7F, 1'b0, acc);
        step(1'b0, 4'd0, 8'd0, 1'b1, acc);
        chk("multi_hold", en_reg_pwm_7_0, 8'h00);
        idle(1);
        chk("multi_pwm", en_reg_pwm_7_0, 8'h0F);
        chk("multi_duty", pwm_duty_cycle, 8'h7F);

        // Timeout commit, write held across COMMIT
        step(1'b1, 4'd3, 8'h11, 1'b0, acc);
        idle(T - 1);
        chk("to_early", 8'(commit_pulse), 8'd0);
        idle(1);
        chk("to_commit", 8'(commit_pulse), 8'd1);
        chk("to_ready", 8'(wr_ready), 8'd0);
        step(1'b1, 4'd1, 8'h22, 1'b0, acc);
        chk("to_val", en_reg_pwm_15_8, 8'h11);
        chk("to_blocked", en_reg_out_15_8, 8'h00);
        step(1'b1, 4'd1, 8'h22, 1'b0, acc);
        chk("to_accept", en_reg_out_15_8, 8'h22);

        // Bad address
        step(1'b1, 4'd7, 8'hFF, 1'b0, acc);
        chk("err_pulse", 8'(addr_err), 8'd1);
        idle(1);
        chk("err_end", 8'(addr_err), 8'd0);

        // Staged write coincident with period_end in PENDING
        step(1'b1, 4'd4, 8'h55, 1'b0, acc);
        step(1'b1, 4'd4, 8'h66, 1'b1, acc);
        idle(1);
        chk("coinc_duty", pwm_duty_cycle, 8'h66);

        // Staged write in IDLE with period_end waits for next boundary
        step(1'b1, 4'd2, 8'h44, 1'b1, acc);
        chk("idle_pe_wait", 8'(commit_pulse), 8'd0);
        step(1'b1, 4'd0, 8'h5A, 1'b0, acc);
        chk("imm_in_pend", en_reg_out_7_0, 8'h5A);
        chk("imm_pend_keep", 8'(pending), 8'h04);
        step(1'b0, 4'd0, 8'd0, 1'b1, acc);
        idle(1);
        chk("idle_pe_val", en_reg_pwm_7_0, 8'h44);

        // Reset mid-PENDING discards everything
        step(1'b1, 4'd4, 8'h33, 1'b0, acc);
        idle(2);
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        chk("rst_duty", pwm_duty_cycle, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        idle(T + 2);
        chk("rst_nocommit", pwm_duty_cycle, 8'h00);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 2) != 0),
                 4'($urandom_range(0, 7)),
                 8'($urandom),
                 1'($urandom_range(0, 9) == 0), acc);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
